// File: rtl/io_display_bank_if.sv
// io_display_bank_if -- processor bus between the CPU and the I/O display bank.
//   wren  : write strobe (master -> slave)
//   addr  : ADDR_W address (master -> slave)
//   wdata : DATA_W write data (master -> slave)
//   rdata : DATA_W read data, one cycle after addr (slave -> master)
interface io_display_bank_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              wren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output wren, output addr, output wdata, input rdata);
   modport slave  (input wren, input addr, input wdata, output rdata);
endinterface

// File: rtl/io_display_bank.sv
// io_display_bank -- memory-mapped display/switch peripheral.
//   NUM_CH writable display registers at IO_BASE..IO_BASE+NUM_CH-1, a
//   two-flop synchronised switch register at IO_BASE+NUM_CH (read-only),
//   registered read data (1-cycle latency), and active-low 7-segment
//   drive of the register chosen by a manual select or an auto-scan timer.
// Ports:
//   clock, reset      : rising-edge clock, async active-low reset
//   bus (slave)       : wren/addr/wdata in, rdata out
//   inp               : raw asynchronous switch inputs
//   mode              : 0 manual select, 1 auto-scan
//   sel_manual        : channel used in manual mode (clamped to NUM_CH-1)
//   ch_now            : channel currently displayed
//   seg               : NUM_DIG digits, {dp,g,f,e,d,c,b,a}, active-low
// Optional: define IO_DISPLAY_LZ_BLANK_EN for leading-zero blanking.
module io_display_bank #(
   parameter int              DATA_W   = 16,
   parameter int              NUM_CH   = 4,
   parameter int              ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] IO_BASE = 12'hFF0,
   parameter int              SCAN_DIV = 50000000
) (
   input  logic                clock,
   input  logic                reset,
   io_display_bank_if.slave    bus,
   input  logic [DATA_W-1:0]   inp,
   input  logic                mode,
   input  logic [3:0]          sel_manual,
   output logic [3:0]          ch_now,
   output logic [DATA_W*2-1:0] seg
);
   localparam int NUM_DIG = DATA_W / 4;
   localparam int IDX_W   = $clog2(NUM_CH);
   localparam int CNT_W   = $clog2(SCAN_DIV);
   localparam logic [ADDR_W-1:0] CH_A      = ADDR_W'(NUM_CH);
   localparam logic [4:0]        CH_5      = 5'(NUM_CH);
   localparam logic [3:0]        CH_LAST   = 4'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
      endcase
   endfunction

   logic [NUM_CH-1:0][DATA_W-1:0] regs_q;
   logic [DATA_W-1:0]             sync1_q, sync2_q, rdata_q, rdata_d;
   logic [3:0]                    ch_q, ch_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NUM_DIG-1:0][7:0]       seg_q, seg_d;

   // Address decode; the explicit lower-bound check keeps addresses below
   // IO_BASE from aliasing into the window through subtraction wrap.
   logic [ADDR_W-1:0] k;
   logic              in_win, hit_reg, hit_inp;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] cur;

   assign k       = bus.addr - IO_BASE;
   assign in_win  = (bus.addr >= IO_BASE);
   assign hit_reg = in_win && (k < CH_A);
   assign hit_inp = in_win && (k == CH_A);
   assign idx     = k[IDX_W-1:0];
   assign cur     = regs_q[ch_q[IDX_W-1:0]];

   always_comb begin
      rdata_d = '0;
      if (hit_reg)      rdata_d = regs_q[idx];
      else if (hit_inp) rdata_d = sync2_q;
   end

   // Channel select: manual clamps to the last channel; auto steps once per
   // SCAN_DIV cycles. The counter idles at 0 in manual so entering auto
   // starts a full period from the current channel.
   always_comb begin
      ch_d  = ch_q;
      cnt_d = '0;
      if (!mode) begin
         ch_d = ({1'b0, sel_manual} >= CH_5) ? CH_LAST : sel_manual;
      end else if (cnt_q == SCAN_LAST) begin
         ch_d = (ch_q == CH_LAST) ? 4'd0 : ch_q + 4'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
`ifdef IO_DISPLAY_LZ_BLANK_EN
      logic lead;
      lead  = 1'b1;
`endif
      seg_d = '0;
      for (int d = NUM_DIG - 1; d >= 0; d--) begin
         seg_d[d] = hex7(cur[4*d +: 4]);
`ifdef IO_DISPLAY_LZ_BLANK_EN
         // Blank while still in the leading-zero run; digit 0 always shows.
         if (d != 0 && lead && cur[4*d +: 4] == 4'h0) seg_d[d] = 8'hFF;
         else lead = 1'b0;
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         regs_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         rdata_q <= '0;
         ch_q    <= '0;
         cnt_q   <= '0;
         seg_q   <= {NUM_DIG{8'hC0}};
      end else begin
         if (bus.wren && hit_reg) regs_q[idx] <= bus.wdata;
         sync1_q <= inp;
         sync2_q <= sync1_q;
         rdata_q <= rdata_d;
         ch_q    <= ch_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign ch_now    = ch_q;
   assign seg       = seg_q;
endmodule

// File: tb/tb_io_display_bank.sv
module tb_io_display_bank;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] inp = '0;
   logic        mode = 1'b0;
   logic [3:0]  sel_manual = '0;
   logic [3:0]  ch_now;
   logic [31:0] seg;
   int          n_cmp = 0;
   int          n_err = 0;

   io_display_bank_if #(.ADDR_W(12), .DATA_W(16)) bus ();

   io_display_bank #(.DATA_W(16), .NUM_CH(4), .ADDR_W(12), .IO_BASE(12'hFF0), .SCAN_DIV(4)) dut (
      .clock(clock), .reset(reset), .bus(bus), .inp(inp), .mode(mode),
      .sel_manual(sel_manual), .ch_now(ch_now), .seg(seg)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [15:0] d);
      bus.wren = 1'b1; bus.addr = a; bus.wdata = d;
      step();
      bus.wren = 1'b0;
   endtask

   task automatic test_reset();
      bus.wren = 1'b0; bus.addr = 12'h000; bus.wdata = '0;
      #12;
      n_cmp++; if (seg !== 32'hC0C0C0C0) begin n_err++; $display("FAIL reset_seg got %h want C0C0C0C0", seg); end
      n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0000", bus.rdata); end
      n_cmp++; if (ch_now !== 4'd0) begin n_err++; $display("FAIL reset_ch got %0d want 0", ch_now); end
      @(negedge clock); reset = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      mode = 1'b0; sel_manual = 4'd2;
      wr(12'hFF2, 16'h12AF);
      n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL same_cycle_old got %h want 0000", bus.rdata); end
      step();
      n_cmp++; if (bus.rdata !== 16'h12AF) begin n_err++; $display("FAIL read_ff2 got %h want 12AF", bus.rdata); end
      n_cmp++; if (seg !== 32'hF9A4888E) begin n_err++; $display("FAIL seg_12af got %h want F9A4888E", seg); end
      n_cmp++; if (ch_now !== 4'd2) begin n_err++; $display("FAIL manual_ch got %0d want 2", ch_now); end
   endtask

   task automatic test_unmapped();
      wr(12'hFF7, 16'hFFFF);
      wr(12'h100, 16'hFFFF);
      wr(12'hFF4, 16'hFFFF);
      bus.addr = 12'hFF7; step();
      n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL read_ff7 got %h want 0000", bus.rdata); end
      bus.addr = 12'h100; step();
      n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL read_100 got %h want 0000", bus.rdata); end
      for (int i = 0; i < 4; i++) begin
         logic [15:0] exp_v;
         exp_v = (i == 2) ? 16'h12AF : 16'h0000;
         bus.addr = 12'hFF0 + 12'(i); step();
         n_cmp++; if (bus.rdata !== exp_v) begin n_err++; $display("FAIL reg_intact%0d got %h want %h", i, bus.rdata, exp_v); end
      end
      sel_manual = 4'd9; step();
      n_cmp++; if (ch_now !== 4'd3) begin n_err++; $display("FAIL sel9_clamp got %0d want 3", ch_now); end
      sel_manual = 4'd4; step();
      n_cmp++; if (ch_now !== 4'd3) begin n_err++; $display("FAIL sel4_clamp got %0d want 3", ch_now); end
      sel_manual = 4'd1; step();
      n_cmp++; if (ch_now !== 4'd1) begin n_err++; $display("FAIL sel1 got %0d want 1", ch_now); end
   endtask

   task automatic test_inp_sync();
      bus.addr = 12'hFF4; step(); step(); step();
      inp = 16'hBEEF;
      step(); step();
      n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL inp_early got %h want 0000", bus.rdata); end
      step();
      n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL inp_read got %h want BEEF", bus.rdata); end
   endtask

   task automatic test_auto();
      logic [7:0] g_tab [4];
      g_tab = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
      mode = 1'b0; sel_manual = 4'd0;
      for (int i = 0; i < 4; i++) wr(12'hFF0 + 12'(i), 16'(i + 1));
      bus.addr = 12'hFF0; step(); step();
      mode = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         logic [3:0] exp_ch;
         logic [7:0] exp_d0;
         step();
         exp_ch = 4'((k / 4) % 4);
         exp_d0 = g_tab[((k - 1) / 4) % 4];
         n_cmp++; if (ch_now !== exp_ch) begin n_err++; $display("FAIL auto_ch k=%0d got %0d want %0d", k, ch_now, exp_ch); end
         n_cmp++; if (seg[7:0] !== exp_d0) begin n_err++; $display("FAIL auto_d0 k=%0d got %h want %h", k, seg[7:0], exp_d0); end
      end
      // Write channel 0 on the edge that advances to channel 1.
      bus.wren = 1'b1; bus.addr = 12'hFF0; bus.wdata = 16'h0055;
      step();
      bus.wren = 1'b0;
      n_cmp++; if (ch_now !== 4'd1) begin n_err++; $display("FAIL adv_ch got %0d want 1", ch_now); end
      n_cmp++; if (seg[7:0] !== 8'hF9) begin n_err++; $display("FAIL adv_seg got %h want F9", seg[7:0]); end
      n_cmp++; if (bus.rdata !== 16'h0001) begin n_err++; $display("FAIL adv_old got %h want 0001", bus.rdata); end
      step();
      n_cmp++; if (bus.rdata !== 16'h0055) begin n_err++; $display("FAIL adv_new got %h want 0055", bus.rdata); end
      n_cmp++; if (seg[7:0] !== 8'hA4) begin n_err++; $display("FAIL adv_seg2 got %h want A4", seg[7:0]); end
      mode = 1'b0;
   endtask

   task automatic test_lz();
      logic [31:0] e5, e0, ea;
`ifdef IO_DISPLAY_LZ_BLANK_EN
      e5 = 32'hFFFFFF92; e0 = 32'hFFFFFFC0; ea = 32'hFF88C092;
`else
      e5 = 32'hC0C0C092; e0 = 32'hC0C0C0C0; ea = 32'hC088C092;
`endif
      mode = 1'b0; sel_manual = 4'd1;
      wr(12'hFF1, 16'h0005); step();
      n_cmp++; if (seg !== e5) begin n_err++; $display("FAIL lz_0005 got %h want %h", seg, e5); end
      wr(12'hFF1, 16'h0000); step();
      n_cmp++; if (seg !== e0) begin n_err++; $display("FAIL lz_0000 got %h want %h", seg, e0); end
      wr(12'hFF1, 16'h0A05); step();
      n_cmp++; if (seg !== ea) begin n_err++; $display("FAIL lz_0a05 got %h want %h", seg, ea); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ez;
`ifdef IO_DISPLAY_LZ_BLANK_EN
      ez = 32'hFFFFFFC0;
`else
      ez = 32'hC0C0C0C0;
`endif
      bus.addr = 12'hFF1; mode = 1'b1;
      repeat (6) step();
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (seg !== 32'hC0C0C0C0) begin n_err++; $display("FAIL mid_rst_seg got %h want C0C0C0C0", seg); end
      n_cmp++; if (ch_now !== 4'd0) begin n_err++; $display("FAIL mid_rst_ch got %0d want 0", ch_now); end
      n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL mid_rst_rdata got %h want 0000", bus.rdata); end
      step();
      reset = 1'b1; mode = 1'b0; sel_manual = 4'd1;
      step();
      n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL post_rst_reg got %h want 0000", bus.rdata); end
      step();
      n_cmp++; if (seg !== ez) begin n_err++; $display("FAIL post_rst_seg got %h want %h", seg, ez); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_unmapped();
      test_inp_sync();
      test_auto();
      test_lz();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
